// File: rtl/fire_squeeze_seq.sv
// Sequencer for a 1x1 fire-module squeeze layer. It streams the ifm pixel-outer and
// channel-inner, then serialises each captured output vector into the ofm RAM.
module fire_squeeze_seq #(
  parameter int WIDTH  = 16,
  parameter int CHIN   = 512,
  parameter int CHOUT  = 64,
  parameter int WOUT   = 16,
  parameter int IFM_AW = $clog2(CHIN*WOUT*WOUT),
  parameter int OFM_AW = $clog2(CHOUT*WOUT*WOUT)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_i,
  output logic                        ifm_rd_en,
  output logic [IFM_AW-1:0]           ifm_rd_addr,
  output logic                        layer_en_o,
  input  logic                        sample_i,
  input  logic [CHOUT-1:0][WIDTH-1:0] ofm_i,
  output logic                        ofm_wr_en,
  output logic [OFM_AW-1:0]           ofm_wr_addr,
  output logic [WIDTH-1:0]            ofm_wr_data,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        overrun_o
);

  localparam int          NPIX   = WOUT * WOUT;
  localparam int unsigned NPIX_U = NPIX;
  localparam int          CW     = (CHIN > 1)  ? $clog2(CHIN)  : 1;
  localparam int          PW     = (NPIX > 1)  ? $clog2(NPIX)  : 1;
  localparam int          KW     = (CHOUT > 1) ? $clog2(CHOUT) : 1;
  localparam int          SW     = $clog2(NPIX + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t                      state;
  logic [CW-1:0]               c;
  logic [PW-1:0]               p;
  logic [SW-1:0]               smp_cnt;
  logic [PW-1:0]               pix;
  logic [KW-1:0]               k;
  logic [KW-1:0]               k_nx;
  logic [CHOUT-1:0][WIDTH-1:0] bank_p1;
  logic                        c_last;
  logic                        p_last;
  logic                        k_last;
  logic                        start_go;
  logic                        smp_ok;
  logic                        ser_free;

  function automatic logic [IFM_AW-1:0] ifm_addr(input int unsigned ci, input int unsigned pi);
    return IFM_AW'(ci * NPIX_U + pi);
  endfunction

  function automatic logic [OFM_AW-1:0] ofm_addr(input int unsigned ki, input int unsigned pi);
    return OFM_AW'(ki * NPIX_U + pi);
  endfunction

  assign c_last   = (c == CW'(CHIN - 1));
  assign p_last   = (p == PW'(NPIX - 1));
  assign k_last   = (k == KW'(CHOUT - 1));
  assign k_nx     = k + 1'b1;
  assign start_go = (state == S_IDLE) && start_i;
  assign smp_ok   = sample_i && ((state == S_READ) || (state == S_DRAIN)) &&
                    (smp_cnt != SW'(NPIX));
  // A new vector may land on the cycle that shows the final word of the previous one.
  assign ser_free = !ofm_wr_en || k_last;

  // Read side: layer FSM and ifm address walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      c           <= '0;
      p           <= '0;
      ifm_rd_en   <= 1'b0;
      ifm_rd_addr <= '0;
      layer_en_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      layer_en_o <= ifm_rd_en;
      done_o     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state       <= S_READ;
            busy_o      <= 1'b1;
            ifm_rd_en   <= 1'b1;
            ifm_rd_addr <= '0;
            c           <= '0;
            p           <= '0;
          end
        end
        S_READ: begin
          if (c_last && p_last) begin
            state       <= S_DRAIN;
            ifm_rd_en   <= 1'b0;
            ifm_rd_addr <= '0;
            c           <= '0;
            p           <= '0;
          end else if (c_last) begin
            c           <= '0;
            p           <= p + 1'b1;
            ifm_rd_addr <= ifm_addr(32'd0, 32'(p) + 32'd1);
          end else begin
            c           <= c + 1'b1;
            ifm_rd_addr <= ifm_addr(32'(c) + 32'd1, 32'(p));
          end
        end
        S_DRAIN: begin
          if ((smp_cnt == SW'(NPIX)) && (!ofm_wr_en || k_last)) begin
            state  <= S_DONE;
            done_o <= 1'b1;
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Capture stage: shadow bank holds the vector while its words are written out
  always_ff @(posedge clk) begin
    if (smp_ok && ser_free) begin
      bank_p1 <= ofm_i;
    end
  end

  // Write side: sample counting, serialiser and overrun flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt     <= '0;
      pix         <= '0;
      k           <= '0;
      ofm_wr_en   <= 1'b0;
      ofm_wr_addr <= '0;
      ofm_wr_data <= '0;
      overrun_o   <= 1'b0;
    end else begin
      if (start_go) begin
        smp_cnt <= '0;
      end else if (smp_ok) begin
        smp_cnt <= smp_cnt + 1'b1;
      end

      if (smp_ok && ser_free) begin
        ofm_wr_en   <= 1'b1;
        k           <= '0;
        pix         <= smp_cnt[PW-1:0];
        ofm_wr_addr <= ofm_addr(32'd0, 32'(smp_cnt));
        ofm_wr_data <= ofm_i[0];
      end else if (ofm_wr_en && !k_last) begin
        k           <= k_nx;
        ofm_wr_addr <= ofm_addr(32'(k_nx), 32'(pix));
        ofm_wr_data <= bank_p1[k_nx];
      end else begin
        ofm_wr_en   <= 1'b0;
        k           <= '0;
        ofm_wr_addr <= '0;
        ofm_wr_data <= '0;
      end

      if (smp_ok && !ser_free) begin
        overrun_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fire_squeeze_seq.sv
// Bench for fire_squeeze_seq at CHIN=4, CHOUT=2, WOUT=2: a literal vector table for the
// basic layer, plus randomized sample schedules against a schedule-level reference model.
module tb_fire_squeeze_seq;

  localparam int CHIN  = 4;
  localparam int CHOUT = 2;
  localparam int WOUT  = 2;
  localparam int NPIX  = WOUT * WOUT;
  localparam int NRD   = CHIN * NPIX;
  localparam int IAW   = 4;
  localparam int OAW   = 3;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   start_i;
  logic                   ifm_rd_en;
  logic [IAW-1:0]         ifm_rd_addr;
  logic                   layer_en_o;
  logic                   sample_i;
  logic [CHOUT-1:0][15:0] ofm_i;
  logic                   ofm_wr_en;
  logic [OAW-1:0]         ofm_wr_addr;
  logic [15:0]            ofm_wr_data;
  logic                   busy_o;
  logic                   done_o;
  logic                   overrun_o;

  fire_squeeze_seq #(
    .WIDTH(16), .CHIN(CHIN), .CHOUT(CHOUT), .WOUT(WOUT), .IFM_AW(IAW), .OFM_AW(OAW)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i),
    .ifm_rd_en(ifm_rd_en), .ifm_rd_addr(ifm_rd_addr), .layer_en_o(layer_en_o),
    .sample_i(sample_i), .ofm_i(ofm_i),
    .ofm_wr_en(ofm_wr_en), .ofm_wr_addr(ofm_wr_addr), .ofm_wr_data(ofm_wr_data),
    .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit smp; bit rd; int addr; bit len; bit we; int wa; int wd; bit dn; bit bsy;
  } row_t;

  row_t        tbl[20];
  int          nvec = 0;
  int          nerr = 0;
  int          sched[$];
  logic [15:0] sdata[8][CHOUT];
  bit          ovr_glob = 1'b0;
  int          n;
  int          t;

  function automatic row_t mk(bit smp, bit rd, int addr, bit len, bit we, int wa, int wd,
                              bit dn, bit bsy);
    row_t r;
    r.smp = smp; r.rd = rd; r.addr = addr; r.len = len; r.we = we;
    r.wa = wa; r.wd = wd; r.dn = dn; r.bsy = bsy;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " ifm_rd_en"},   32'(ifm_rd_en),   32'd0);
    chk({tag, " ifm_rd_addr"}, 32'(ifm_rd_addr), 32'd0);
    chk({tag, " layer_en_o"},  32'(layer_en_o),  32'd0);
    chk({tag, " ofm_wr_en"},   32'(ofm_wr_en),   32'd0);
    chk({tag, " ofm_wr_addr"}, 32'(ofm_wr_addr), 32'd0);
    chk({tag, " ofm_wr_data"}, 32'(ofm_wr_data), 32'd0);
    chk({tag, " busy_o"},      32'(busy_o),      32'd0);
    chk({tag, " done_o"},      32'(done_o),      32'd0);
    chk({tag, " overrun_o"},   32'(overrun_o),   32'd0);
  endtask

  task automatic check_row(input int r, input bit rd, input int addr, input bit len,
                           input bit we, input int wa, input int wd, input bit dn,
                           input bit bsy, input bit ovr);
    chk($sformatf("rd_en r%0d", r), 32'(ifm_rd_en), 32'(rd));
    if (rd) chk($sformatf("rd_addr r%0d", r), 32'(ifm_rd_addr), addr);
    chk($sformatf("layer_en r%0d", r), 32'(layer_en_o), 32'(len));
    chk($sformatf("wr_en r%0d", r), 32'(ofm_wr_en), 32'(we));
    if (we) begin
      chk($sformatf("wr_addr r%0d", r), 32'(ofm_wr_addr), wa);
      chk($sformatf("wr_data r%0d", r), 32'(ofm_wr_data), wd);
    end
    chk($sformatf("done r%0d", r), 32'(done_o), 32'(dn));
    chk($sformatf("busy r%0d", r), 32'(busy_o), 32'(bsy));
    chk($sformatf("overrun r%0d", r), 32'(overrun_o), 32'(ovr));
  endtask

  // Reference: reads follow the (p, c) nest, each accepted sample owns CHOUT write slots,
  // a sample landing before the previous vector's last slot is dropped and flags overrun.
  task automatic run_layer(input int restart_row);
    int cnt, ser_last, last_acc, ovr_row, exp_done, nrows, j, ts;
    bit ewe[80];
    int ewa[80];
    int ewd[80];
    cnt = 0; ser_last = -100; last_acc = -1; ovr_row = -1;
    for (int i = 0; i < 80; i++) begin
      ewe[i] = 1'b0; ewa[i] = 0; ewd[i] = 0;
    end
    for (int s = 0; s < sched.size(); s++) begin
      for (int k = 0; k < CHOUT; k++) sdata[s][k] = 16'($urandom);
      ts = sched[s];
      if (cnt < NPIX) begin
        if (ts >= ser_last) begin
          for (int k = 0; k < CHOUT; k++) begin
            ewe[ts+1+k] = 1'b1;
            ewa[ts+1+k] = k * NPIX + cnt;
            ewd[ts+1+k] = int'(sdata[s][k]);
          end
          ser_last = ts + CHOUT;
        end else if (ovr_row < 0) begin
          ovr_row = ts;
        end
        cnt++;
        last_acc = ts;
      end
    end
    exp_done = NRD;
    if (last_acc + 1 > exp_done) exp_done = last_acc + 1;
    if (ser_last > exp_done) exp_done = ser_last;
    exp_done++;
    nrows = exp_done + 2;

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    j = 0;
    for (int r = 0; r < nrows; r++) begin
      check_row(r, r < NRD, (r % CHIN) * NPIX + r / CHIN, (r >= 1) && (r <= NRD),
                ewe[r], ewa[r], ewd[r], r == exp_done, r <= exp_done,
                ovr_glob || ((ovr_row >= 0) && (r > ovr_row)));
      start_i  = (r == restart_row);
      sample_i = 1'b0;
      if ((j < sched.size()) && (sched[j] == r)) begin
        sample_i = 1'b1;
        for (int k = 0; k < CHOUT; k++) ofm_i[k] = sdata[j][k];
        j++;
      end
      tick();
    end
    sample_i = 1'b0;
    start_i  = 1'b0;
    if (ovr_row >= 0) ovr_glob = 1'b1;
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; sample_i = 1'b0; ofm_i = '0;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();

    //           smp rd addr len we wa wd    dn bsy
    tbl[0]  = mk(0, 1, 0,  0, 0, 0, 0,     0, 1);
    tbl[1]  = mk(0, 1, 4,  1, 0, 0, 0,     0, 1);
    tbl[2]  = mk(0, 1, 8,  1, 0, 0, 0,     0, 1);
    tbl[3]  = mk(1, 1, 12, 1, 0, 0, 0,     0, 1);
    tbl[4]  = mk(0, 1, 1,  1, 1, 0, 'h11,  0, 1);
    tbl[5]  = mk(0, 1, 5,  1, 1, 4, 'h22,  0, 1);
    tbl[6]  = mk(0, 1, 9,  1, 0, 0, 0,     0, 1);
    tbl[7]  = mk(1, 1, 13, 1, 0, 0, 0,     0, 1);
    tbl[8]  = mk(0, 1, 2,  1, 1, 1, 'h22,  0, 1);
    tbl[9]  = mk(0, 1, 6,  1, 1, 5, 'h44,  0, 1);
    tbl[10] = mk(0, 1, 10, 1, 0, 0, 0,     0, 1);
    tbl[11] = mk(1, 1, 14, 1, 0, 0, 0,     0, 1);
    tbl[12] = mk(0, 1, 3,  1, 1, 2, 'h33,  0, 1);
    tbl[13] = mk(0, 1, 7,  1, 1, 6, 'h66,  0, 1);
    tbl[14] = mk(0, 1, 11, 1, 0, 0, 0,     0, 1);
    tbl[15] = mk(1, 1, 15, 1, 0, 0, 0,     0, 1);
    tbl[16] = mk(0, 0, 0,  1, 1, 3, 'h44,  0, 1);
    tbl[17] = mk(0, 0, 0,  0, 1, 7, 'h88,  0, 1);
    tbl[18] = mk(0, 0, 0,  0, 0, 0, 0,     1, 1);
    tbl[19] = mk(0, 0, 0,  0, 0, 0, 0,     0, 0);

    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    n = 0;
    for (int r = 0; r < 20; r++) begin
      check_row(r, tbl[r].rd, tbl[r].addr, tbl[r].len, tbl[r].we, tbl[r].wa, tbl[r].wd,
                tbl[r].dn, tbl[r].bsy, 1'b0);
      sample_i = tbl[r].smp;
      if (tbl[r].smp) begin
        ofm_i[0] = 16'(16'h0011 * (n + 1));
        ofm_i[1] = 16'(16'h0022 * (n + 1));
        n++;
      end
      tick();
      sample_i = 1'b0;
    end

    // Back-to-back vectors: each sample lands on the previous vector's last write
    sched = '{10, 12, 14, 16};
    run_layer(-1);

    // Sample while idle must not count or write; a start mid-layer must not restart it
    sample_i = 1'b1;
    ofm_i[0] = 16'hdead;
    ofm_i[1] = 16'hbeef;
    tick();
    sample_i = 1'b0;
    chk("idle sample wr_en", 32'(ofm_wr_en), 32'd0);
    chk("idle sample busy", 32'(busy_o), 32'd0);
    tick();
    chk("idle sample wr_en late", 32'(ofm_wr_en), 32'd0);
    sched = '{3, 7, 11, 15};
    run_layer(5);

    // Randomized sample timing, including spacings that overrun and surplus samples
    for (int l = 0; l < 4; l++) begin
      sched.delete();
      t = $urandom_range(0, 3);
      for (int i = 0; i < NPIX; i++) begin
        sched.push_back(t);
        t += $urandom_range(1, 6);
      end
      if ($urandom_range(0, 1) == 1) sched.push_back(t);
      run_layer(-1);
    end

    // Overrun: second sample one cycle into the first vector's writes
    sched = '{3, 4, 8, 12};
    run_layer(-1);

    // Asynchronous reset in the middle of the read window
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int r = 0; r < 7; r++) tick();
    chk("pre-reset rd_addr", 32'(ifm_rd_addr), 32'd13);
    #2;
    rst = 1'b1;
    #1;
    check_reset("async reset");
    tick();
    rst = 1'b0;
    tick();
    check_reset("post reset");
    ovr_glob = 1'b0;
    sched = '{3, 7, 11, 15};
    run_layer(-1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fire_squeeze_seq.md
Name: fire_squeeze_seq

Overview:
- Sequencer for one 1x1 squeeze layer (fire-module squeeze).
- Streams the input feature map out of the activation RAM in the pixel-outer, channel-inner order the MAC array expects, and drives the layer enable.
- Captures each parallel output vector on the datapath sample pulse and serialises it into the output activation RAM.
- Reports layer completion to the top-level layer chain.

Parameters:
WIDTH, 16, activation word width
CHIN, 512, input channels (MAC accumulation length per pixel)
CHOUT, 64, output channels (parallel MAC/DSP count); must be <= CHIN
WOUT, 16, output spatial dimension; NPIX = WOUT*WOUT
IFM_AW, $clog2(CHIN*WOUT*WOUT), ifm read address width
OFM_AW, $clog2(CHOUT*WOUT*WOUT), ofm write address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start_i  in  1  one-cycle pulse: upstream layer finished, begin this layer
ifm_rd_en  out  1  ifm RAM read strobe
ifm_rd_addr  out  IFM_AW  ifm RAM address = c*NPIX + p
layer_en_o  out  1  enable to squeeze datapath, equals ifm_rd_en delayed 1 cycle (RAM latency)
sample_i  in  1  datapath output-valid pulse, one per pixel
ofm_i  in  CHOUT x WIDTH  datapath output vector, valid when sample_i=1
ofm_wr_en  out  1  ofm RAM write strobe
ofm_wr_addr  out  OFM_AW  ofm RAM address = k*NPIX + pix
ofm_wr_data  out  WIDTH  ofm word for channel k
busy_o  out  1  high from start acceptance until done_o
done_o  out  1  one-cycle pulse after the last ofm write
overrun_o  out  1  sticky: sample_i arrived while serialiser still busy

Behaviour:
- Reset (async, rst=1), all outputs 0: ifm_rd_en, ifm_rd_addr, layer_en_o, ofm_wr_en, ofm_wr_addr, ofm_wr_data, busy_o, done_o, overrun_o. Counters 0, FSM IDLE. Reset mid-layer aborts immediately; nothing resumes after release.
- FSM states:
  - IDLE -> READ on start_i.
  - READ -> DRAIN after the read at p=NPIX-1, c=CHIN-1.
  - DRAIN -> DONE when sample count = NPIX and serialiser idle.
  - DONE -> IDLE after 1 cycle.
- start_i outside IDLE is ignored.
- READ:
  - ifm_rd_en=1 every cycle, exactly CHIN*NPIX consecutive cycles, no bubbles.
  - c increments each cycle; at c=CHIN-1 it wraps to 0 and p increments.
  - First address 0. Second address NPIX. Address after (p, CHIN-1) is p+1.
- layer_en_o is a 1-cycle registered copy of ifm_rd_en, so it is high for CHIN*NPIX cycles.
- busy_o is 1 from the cycle after start_i through the DONE cycle.
- Capture and serialiser:
  - On sample_i=1, register all CHOUT words of ofm_i into a shadow bank, latch pix = samples received so far (0..NPIX-1), increment the sample count, set k=0.
  - Serialiser starts the next cycle: one write per cycle for CHOUT cycles.
  - Write fields: ofm_wr_en=1, ofm_wr_addr=k*NPIX+pix, ofm_wr_data=bank[k].
- Simultaneous events:
  - sample_i in the same cycle as the serialiser's last write (k=CHOUT-1): legal. The bank reloads and writing continues the next cycle with no gap.
  - sample_i earlier than that: overrun_o sets (sticky until rst). The new vector is dropped and the sample count still increments.
- sample_i in IDLE is ignored and does not count.
- Samples beyond NPIX are ignored.
- done_o is 1 in the DONE cycle only. The last ofm write precedes it by exactly 1 cycle.
- Arithmetic:
  - Address products use unsigned multiply by the constant NPIX, truncated to IFM_AW/OFM_AW.
  - Counter widths: c holds 0..CHIN-1, p and pix hold 0..NPIX-1, k holds 0..CHOUT-1.

Test Plan:
- Basic sequencing, CHIN=4, CHOUT=2, WOUT=2 (NPIX=4): pulse start_i -> ifm_rd_addr sequence 0,4,8,12,1,5,9,13,...,15 over 16 cycles; layer_en_o is the same window delayed 1.
- Write-back, same params: model pulses sample_i every 4 cycles with ofm_i={0x0011*(pix+1), 0x0022*(pix+1)} -> writes addr0=0x0011, addr4=0x0022, addr1=0x0022, addr5=0x0044, ...; done_o 1 cycle after the 8th write; busy_o then falls.
- Back-to-back: CHIN=CHOUT=2, sample_i every 2 cycles -> continuous ofm_wr_en, no gaps, overrun_o=0.
- Overrun: CHOUT=4, two sample_i 2 cycles apart -> overrun_o=1, only the first vector's 4 words written, sample count=2.
- Start while busy and sample_i in IDLE -> no restart, no write, no count change.
- Reset mid-READ at cycle 7 -> all outputs 0 asynchronously; a new start_i after release restarts from address 0.
